mcp_host_sequencer: RTL and testbench

Host-side command sequencer that sits directly upstream of the 16-bit math coprocessor (MCP). It accepts one operation (A, B, opcode) on a valid/ready port and generates the MCP's 8-bit strobed bus cycles: operand and opcode writes, a fixed compute wait, then four result-byte reads. The 32-bit result X is returned on a valid/ready port. Tristating of the shared data bus is done one level up, using `mcp_data_oe`.

---
 rtl/mcp_host_sequencer_if.sv | 31 +++
 rtl/mcp_host_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_mcp_host_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp_host_sequencer_if.sv
// Command/result handshakes plus the strobed MCP bus of the host sequencer.
// The slave modport is the sequencer; the master modport is its host/bus environment.
interface mcp_host_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [7:0]  cmd_op;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_x;
  logic        busy;
  logic        mcp_wr_n;
  logic        mcp_rd_n;
  logic [2:0]  mcp_addr;
  logic [7:0]  mcp_data_out;
  logic        mcp_data_oe;
  logic [7:0]  mcp_data_in;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, mcp_data_in,
    output cmd_ready, res_valid, res_x, busy,
    output mcp_wr_n, mcp_rd_n, mcp_addr, mcp_data_out, mcp_data_oe
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, mcp_data_in,
    input  cmd_ready, res_valid, res_x, busy,
    input  mcp_wr_n, mcp_rd_n, mcp_addr, mcp_data_out, mcp_data_oe
  );
endinterface

// File: rtl/mcp_host_sequencer.sv
// Host sequencer for the 16-bit math coprocessor: byte-wise operand/opcode writes,
// a fixed compute wait, then four result-byte reads assembled into a 32-bit X.
module mcp_host_sequencer #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 2,
  parameter int COMPUTE_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mcp_host_sequencer_if.slave bus
);

  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_HC  = (HOLD_CYC > COMPUTE_CYC) ? HOLD_CYC : COMPUTE_CYC;
  localparam int MAX_CYC = (MAX_SS > MAX_HC) ? MAX_SS : MAX_HC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] COMPUTE_LD = CNT_W'(COMPUTE_CYC - 1);

  localparam logic [7:0] OP_SQRT = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_W_SETUP, S_W_STROBE, S_W_HOLD,
    S_WAIT, S_R_SETUP, S_R_STROBE, S_R_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [15:0]      r_a, r_b;
  logic [7:0]       r_op;
  logic [31:0]      r_shift;

  logic        r_cmd_ready, r_res_valid, r_busy;
  logic [31:0] r_res_x;
  logic        r_wr_n, r_rd_n, r_oe;
  logic [2:0]  r_addr;
  logic [7:0]  r_dout;

  logic        w_accept, w_last, w_capture, w_done, w_consume;
  logic [15:0] w_a, w_b;
  logic [7:0]  w_op;
  logic        w_write_ph, w_read_ph, w_res_valid_nxt, w_cmd_ready_nxt;
  logic [2:0]  w_addr_nxt;
  logic [7:0]  w_dout_nxt;

  assign w_accept  = bus.cmd_valid && r_cmd_ready;
  assign w_last    = (r_cnt == '0);
  assign w_consume = r_res_valid && bus.res_ready;

  // The first write byte is driven on the accept edge itself, before r_a/r_b/r_op load.
  assign w_a  = w_accept ? bus.cmd_a  : r_a;
  assign w_b  = w_accept ? bus.cmd_b  : r_b;
  assign w_op = w_accept ? bus.cmd_op : r_op;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_W_SETUP;
        w_cnt_nxt   = SETUP_LD;
        w_idx_nxt   = 3'd0;
      end
      S_W_SETUP: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_last) begin
          w_state_nxt = S_W_STROBE;
          w_cnt_nxt   = STROBE_LD;
        end
      end
      S_W_STROBE: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_last) begin
          w_state_nxt = S_W_HOLD;
          w_cnt_nxt   = HOLD_LD;
        end
      end
      S_W_HOLD: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_last) begin
          if (r_idx == 3'd4) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = COMPUTE_LD;
            w_idx_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_W_SETUP;
            w_cnt_nxt   = SETUP_LD;
            // SQRT has no B operand: jump from A[7:0] straight to the opcode byte.
            w_idx_nxt   = (r_idx == 3'd1 && r_op == OP_SQRT) ? 3'd4 : r_idx + 3'd1;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_last) begin
          w_state_nxt = S_R_SETUP;
          w_cnt_nxt   = SETUP_LD;
        end
      end
      S_R_SETUP: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_last) begin
          w_state_nxt = S_R_STROBE;
          w_cnt_nxt   = STROBE_LD;
        end
      end
      S_R_STROBE: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_last) begin
          w_state_nxt = S_R_HOLD;
          w_cnt_nxt   = HOLD_LD;
          w_capture   = 1'b1;
        end
      end
      S_R_HOLD: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_last) begin
          if (r_idx == 3'd3) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 3'd0;
            w_done      = 1'b1;
          end else begin
            w_state_nxt = S_R_SETUP;
            w_cnt_nxt   = SETUP_LD;
            w_idx_nxt   = r_idx + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so pins line up with the state they belong to.
  always_comb begin
    w_write_ph = (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_STROBE) ||
                 (w_state_nxt == S_W_HOLD);
    w_read_ph  = (w_state_nxt == S_R_SETUP) || (w_state_nxt == S_R_STROBE) ||
                 (w_state_nxt == S_R_HOLD);
    w_addr_nxt = 3'd0;
    w_dout_nxt = 8'd0;
    if (w_write_ph) begin
      w_addr_nxt = (w_idx_nxt == 3'd4) ? 3'd7 : w_idx_nxt;
      case (w_idx_nxt)
        3'd0:    w_dout_nxt = w_a[15:8];
        3'd1:    w_dout_nxt = w_a[7:0];
        3'd2:    w_dout_nxt = w_b[15:8];
        3'd3:    w_dout_nxt = w_b[7:0];
        default: w_dout_nxt = w_op;
      endcase
    end else if (w_read_ph) begin
      w_addr_nxt = w_idx_nxt;
    end
    w_res_valid_nxt = w_done || (r_res_valid && !w_consume);
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && !w_res_valid_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_a         <= 16'd0;
      r_b         <= 16'd0;
      r_op        <= 8'd0;
      r_shift     <= 32'd0;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_x     <= 32'd0;
      r_busy      <= 1'b0;
      r_wr_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_addr      <= 3'd0;
      r_dout      <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_a  <= bus.cmd_a;
        r_b  <= bus.cmd_b;
        r_op <= bus.cmd_op;
      end
      if (w_capture) r_shift <= {r_shift[23:0], bus.mcp_data_in};
      if (w_done)    r_res_x <= r_shift;
      r_res_valid <= w_res_valid_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_wr_n      <= (w_state_nxt != S_W_STROBE);
      r_rd_n      <= (w_state_nxt != S_R_STROBE);
      r_oe        <= w_write_ph;
      r_addr      <= w_addr_nxt;
      r_dout      <= w_dout_nxt;
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_x        = r_res_x;
  assign bus.busy         = r_busy;
  assign bus.mcp_wr_n     = r_wr_n;
  assign bus.mcp_rd_n     = r_rd_n;
  assign bus.mcp_addr     = r_addr;
  assign bus.mcp_data_out = r_dout;
  assign bus.mcp_data_oe  = r_oe;

endmodule

// File: tb/tb_mcp_host_sequencer.sv
// Bench for mcp_host_sequencer: MCP bus model, protocol monitor, vector table,
// backpressure and mid-operation reset sequences, and randomized commands.
module tb_mcp_host_sequencer;

  localparam int SETUP_CYC   = 2;
  localparam int STROBE_CYC  = 3;
  localparam int HOLD_CYC    = 2;
  localparam int COMPUTE_CYC = 64;
  localparam int P           = SETUP_CYC + STROBE_CYC + HOLD_CYC;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;

  mcp_host_sequencer_if bus ();

  mcp_host_sequencer #(
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .COMPUTE_CYC(COMPUTE_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Coprocessor arithmetic: 0 signed product, 1 {quot,rem}, 2 (A<<16)/B, 3 sqrt(A) in 8.8 at bit 8.
  function automatic logic [31:0] mcp_math(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] op);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint v, r, t;
    case (op)
      8'd0: return 32'(sa * sb);
      8'd1: return (sb == 0) ? 32'hFFFF_FFFF : {16'(sa / sb), 16'(sa % sb)};
      8'd2: return (sb == 0) ? 32'hFFFF_FFFF : 32'((sa * 65536) / sb);
      8'd3: begin
        v = longint'(a) * 65536;
        r = 0;
        for (int k = 16; k >= 0; k--) begin
          t = r + (longint'(1) << k);
          if (t * t <= v) r = t;
        end
        return 32'(r) << 8;
      end
      default: return {a, b};
    endcase
  endfunction

  // MCP model: latches operand bytes, computes when the opcode is written, serves reads.
  logic [15:0] m_a = 16'd0, m_b = 16'd0;
  logic [31:0] m_res = 32'd0;

  always @(posedge clk) begin
    if (!bus.mcp_wr_n) begin
      case (bus.mcp_addr)
        3'd0: m_a[15:8] <= bus.mcp_data_out;
        3'd1: m_a[7:0]  <= bus.mcp_data_out;
        3'd2: m_b[15:8] <= bus.mcp_data_out;
        3'd3: m_b[7:0]  <= bus.mcp_data_out;
        3'd7: m_res     <= mcp_math(m_a, m_b, bus.mcp_data_out);
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.mcp_addr[1:0])
      2'd0:    bus.mcp_data_in = m_res[31:24];
      2'd1:    bus.mcp_data_in = m_res[23:16];
      2'd2:    bus.mcp_data_in = m_res[15:8];
      default: bus.mcp_data_in = m_res[7:0];
    endcase
  end

  // Bus monitor: records every write/read cycle and checks the strobe protocol.
  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         cyc;
  } xfer_t;

  xfer_t      wq[$];
  xfer_t      rq[$];
  logic       m_prev_wr = 1'b1, m_prev_rd = 1'b1;
  int         m_wr_w = 0, m_rd_w = 0;
  logic [2:0] m_addr = 3'd0;
  logic [7:0] m_data = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev_wr = 1'b1;
      m_prev_rd = 1'b1;
      m_wr_w    = 0;
      m_rd_w    = 0;
    end else begin
      if (!bus.mcp_wr_n || !bus.mcp_rd_n)
        check("strobes_exclusive", 32'(bus.mcp_wr_n | bus.mcp_rd_n), 32'd1);
      if (!bus.mcp_wr_n) begin
        check("oe_during_write", 32'(bus.mcp_data_oe), 32'd1);
        if (m_prev_wr) begin
          wq.push_back('{bus.mcp_addr, bus.mcp_data_out, cyc});
          m_wr_w = 1;
        end else begin
          m_wr_w++;
          check("wr_addr_stable", 32'(bus.mcp_addr), 32'(m_addr));
          check("wr_data_stable", 32'(bus.mcp_data_out), 32'(m_data));
        end
      end else if (!m_prev_wr) begin
        check("wr_strobe_width", 32'(m_wr_w), 32'(STROBE_CYC));
      end
      if (!bus.mcp_rd_n) begin
        check("oe_during_read", 32'(bus.mcp_data_oe), 32'd0);
        if (m_prev_rd) begin
          rq.push_back('{bus.mcp_addr, 8'd0, cyc});
          m_rd_w = 1;
        end else begin
          m_rd_w++;
          check("rd_addr_stable", 32'(bus.mcp_addr), 32'(m_addr));
        end
      end else if (!m_prev_rd) begin
        check("rd_strobe_width", 32'(m_rd_w), 32'(STROBE_CYC));
      end
      m_prev_wr = bus.mcp_wr_n;
      m_prev_rd = bus.mcp_rd_n;
      m_addr    = bus.mcp_addr;
      m_data    = bus.mcp_data_out;
    end
  end

  // Offer a command (called at a negedge) and wait for its accept edge; returns at the next negedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    bit ok = 1'b0;
    wq.delete();
    rq.delete();
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_result(output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!ok) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_after_consume", 32'(bus.res_valid), 32'd0);
  endtask

  // Checks one finished transaction against the rules for write order, read order and timing.
  task automatic verify(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                        input logic [31:0] exp_x, input int exp_lat, input int exp_nwr,
                        input int lat);
    xfer_t ew[$];
    ew.push_back('{3'd0, a[15:8], 0});
    ew.push_back('{3'd1, a[7:0], 0});
    if (op != 8'd3) begin
      ew.push_back('{3'd2, b[15:8], 0});
      ew.push_back('{3'd3, b[7:0], 0});
    end
    ew.push_back('{3'd7, op, 0});
    check("latency", 32'(lat), 32'(exp_lat));
    check("res_x", bus.res_x, exp_x);
    check("write_count", 32'(wq.size()), 32'(exp_nwr));
    if (wq.size() == ew.size()) begin
      for (int i = 0; i < ew.size(); i++) begin
        check($sformatf("write%0d_addr", i), 32'(wq[i].addr), 32'(ew[i].addr));
        check($sformatf("write%0d_data", i), 32'(wq[i].data), 32'(ew[i].data));
      end
    end
    if (wq.size() > 0)
      check("first_strobe_cycle", 32'(wq[0].cyc - acc_cyc + 1), 32'(SETUP_CYC + 1));
    check("read_count", 32'(rq.size()), 32'd4);
    if (rq.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("read%0d_addr", i), 32'(rq[i].addr), 32'(i));
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                         input logic [31:0] exp_x, input int exp_lat, input int exp_nwr);
    int lat;
    issue(a, b, op);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("cmd_ready_after_accept", 32'(bus.cmd_ready), 32'd0);
    wait_result(lat);
    verify(a, b, op, exp_x, exp_lat, exp_nwr, lat);
    consume();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic [31:0] exp_x;
    int          exp_lat;
    int          exp_nwr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat;
    logic [31:0] x0;
    logic [15:0] ra, rb;
    logic [7:0]  rop;
    int          nw;

    vecs[0] = '{16'h7FFF, 16'h7FFF, 8'd0,   32'h3FFF_0001, 127, 5};
    vecs[1] = '{16'hFFF0, 16'h0003, 8'd1,   32'hFFFB_FFFF, 127, 5};
    vecs[2] = '{16'hFD00, 16'hFF00, 8'd1,   32'h0003_0000, 127, 5};
    vecs[3] = '{16'h0002, 16'h1234, 8'd3,   32'h0001_6A00, 113, 3};
    vecs[4] = '{16'h0001, 16'h0002, 8'd2,   32'h0000_8000, 127, 5};
    vecs[5] = '{16'h1234, 16'h5678, 8'hC5,  32'h1234_5678, 127, 5};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 16'd0;
    bus.cmd_b     = 16'd0;
    bus.cmd_op    = 8'd0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_x", bus.res_x, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_wr_n", 32'(bus.mcp_wr_n), 32'd1);
    check("rst_rd_n", 32'(bus.mcp_rd_n), 32'd1);
    check("rst_addr", 32'(bus.mcp_addr), 32'd0);
    check("rst_data_out", 32'(bus.mcp_data_out), 32'd0);
    check("rst_data_oe", 32'(bus.mcp_data_oe), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_x, vecs[i].exp_lat, vecs[i].exp_nwr);

    // Backpressure: a pending result blocks the next command until it is consumed.
    issue(16'h0003, 16'h0005, 8'd0);
    wait_result(lat);
    verify(16'h0003, 16'h0005, 8'd0, 32'h0000_000F, 127, 5, lat);
    x0            = bus.res_x;
    bus.cmd_a     = 16'hFD00;
    bus.cmd_b     = 16'hFF00;
    bus.cmd_op    = 8'd1;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
      check("bp_res_valid_held", 32'(bus.res_valid), 32'd1);
      check("bp_res_x_stable", bus.res_x, x0);
      check("bp_not_busy", 32'(bus.busy), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("bp_consumed", 32'(bus.res_valid), 32'd0);
    check("bp_res_x_kept", bus.res_x, x0);
    check("bp_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    check("bp_still_idle", 32'(bus.busy), 32'd0);
    issue(16'hFD00, 16'hFF00, 8'd1);
    wait_result(lat);
    verify(16'hFD00, 16'hFF00, 8'd1, 32'h0003_0000, 127, 5, lat);
    consume();

    // Reset during the third write strobe.
    issue(16'h1111, 16'h2222, 8'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (wq.size() >= 3 && !bus.mcp_wr_n) break;
    end
    check("midrst_in_third_strobe", 32'(wq.size()), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_n", 32'(bus.mcp_wr_n), 32'd1);
    check("midrst_data_oe", 32'(bus.mcp_data_oe), 32'd0);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("midrst_idle", 32'(bus.busy), 32'd0);
    repeat (COMPUTE_CYC) @(negedge clk);
    run_txn(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].exp_x, vecs[0].exp_lat, vecs[0].exp_nwr);

    // Randomized commands against the coprocessor arithmetic and the bus-ordering rules.
    for (int n = 0; n < 12; n++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = ($urandom_range(0, 4) == 4) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      nw  = (rop == 8'd3) ? 3 : 5;
      issue(ra, rb, rop);
      wait_result(lat);
      verify(ra, rb, rop, mcp_math(ra, rb, rop), (nw + 4) * P + COMPUTE_CYC, nw, lat);
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk);
        check("rand_res_held", 32'(bus.res_valid), 32'd1);
      end
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
